// File: rtl/digit_board_if.sv
// Write-request bus shared by the game-logic (A) and keypad (B) requesters.
interface digit_board_if;
  logic       a_req;
  logic [3:0] a_slot;
  logic [3:0] a_data;
  logic       a_gnt;
  logic       b_req;
  logic [3:0] b_slot;
  logic [3:0] b_data;
  logic       b_gnt;

  modport master (
    output a_req, a_slot, a_data, b_req, b_slot, b_data,
    input  a_gnt, b_gnt
  );

  modport slave (
    input  a_req, a_slot, a_data, b_req, b_slot, b_data,
    output a_gnt, b_gnt
  );
endinterface

// File: rtl/digit_board_ctrl.sv
// Twelve-slot digit board: round-robin write arbitration into a working copy,
// frame-synchronous publishing to the renderer, optional blinking cursor slot.
module digit_board_ctrl #(
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_start,
  input  logic          clr,
  digit_board_if.slave  wr,
  input  logic          cursor_en,
  input  logic [3:0]    cursor_slot,
  output logic [47:0]   numbers_concat,
  output logic          pending
);

  localparam logic [7:0] BlinkLast = 8'(BLINK_FRAMES - 1);

  typedef enum logic [0:0] {StArb, StWrite} state_e;

  state_e      state_q, state_d;
  logic        sel_q, sel_d;    // 1: port B owns the current WRITE
  logic        last_q, last_d;  // 1: B won the most recent grant
  logic        a_gnt_q, a_gnt_d;
  logic        b_gnt_q, b_gnt_d;
  logic [3:0]  working_q [12];
  logic [3:0]  working_d [12];
  logic [47:0] pub_q, pub_d;
  logic        pending_q, pending_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        blink_on_q, blink_on_d;

  logic        win_b;
  logic        wr_en;
  logic        wr_valid;
  logic [3:0]  wr_slot;
  logic [3:0]  wr_data;
  logic        blank_cursor;

  // Arbiter
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    a_gnt_d = 1'b0;
    b_gnt_d = 1'b0;
    win_b   = 1'b0;
    unique case (state_q)
      StArb: begin
        if (wr.a_req || wr.b_req) begin
          // On contention the loser of the previous grant goes first
          win_b   = wr.b_req && (!wr.a_req || !last_q);
          sel_d   = win_b;
          last_d  = win_b;
          a_gnt_d = !win_b;
          b_gnt_d = win_b;
          state_d = StWrite;
        end
      end
      StWrite: state_d = StArb;
      default: state_d = StArb;
    endcase
  end

  // Working copy, publishing, blink and pending tracking
  always_comb begin
    wr_en        = (state_q == StWrite);
    wr_slot      = sel_q ? wr.b_slot : wr.a_slot;
    wr_data      = sel_q ? wr.b_data : wr.a_data;
    wr_valid     = wr_en && (wr_slot < 4'd12);
    blank_cursor = cursor_en && (cursor_slot < 4'd12) && !blink_on_q;

    working_d = working_q;
    if (clr) begin
      for (int i = 0; i < 12; i++) working_d[i] = 4'hF;
    end
    if (wr_valid) working_d[wr_slot] = wr_data;

    pub_d      = pub_q;
    cnt_d      = cnt_q;
    blink_on_d = blink_on_q;
    if (frame_start) begin
      for (int i = 0; i < 12; i++) begin
        pub_d[47 - 4*i -: 4] = (blank_cursor && cursor_slot == 4'(i)) ? 4'hF : working_q[i];
      end
      if (cnt_q == BlinkLast) begin
        cnt_d      = 8'd0;
        blink_on_d = !blink_on_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end

    if (wr_valid || clr) begin
      pending_d = 1'b1;
    end else if (frame_start) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StArb;
      sel_q      <= 1'b0;
      last_q     <= 1'b1;
      a_gnt_q    <= 1'b0;
      b_gnt_q    <= 1'b0;
      for (int i = 0; i < 12; i++) working_q[i] <= 4'hF;
      pub_q      <= 48'hFFFF_FFFF_FFFF;
      pending_q  <= 1'b0;
      cnt_q      <= 8'd0;
      blink_on_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
      a_gnt_q    <= a_gnt_d;
      b_gnt_q    <= b_gnt_d;
      working_q  <= working_d;
      pub_q      <= pub_d;
      pending_q  <= pending_d;
      cnt_q      <= cnt_d;
      blink_on_q <= blink_on_d;
    end
  end

  assign wr.a_gnt         = a_gnt_q;
  assign wr.b_gnt         = b_gnt_q;
  assign numbers_concat   = pub_q;
  assign pending          = pending_q;

endmodule

// File: tb/tb_digit_board_ctrl.sv
// Directed bench for digit_board_ctrl: vector table for single writes plus
// hand-written sequences for reset, contention, same-cycle and blink cases.
module tb_digit_board_ctrl;

  logic        clk;
  logic        rst;
  logic        frame_start;
  logic        clr;
  logic        cursor_en;
  logic [3:0]  cursor_slot;
  logic [47:0] numbers_concat;
  logic        pending;

  digit_board_if bus ();

  digit_board_ctrl #(.BLINK_FRAMES(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .frame_start    (frame_start),
    .clr            (clr),
    .wr             (bus),
    .cursor_en      (cursor_en),
    .cursor_slot    (cursor_slot),
    .numbers_concat (numbers_concat),
    .pending        (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    bit          port;       // 0: A, 1: B
    logic [3:0]  slot;
    logic [3:0]  data;
    bit          exp_pend;   // pending after the write, before the frame
    logic [47:0] exp_concat; // board after the following frame_start
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic frame;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // Issue one write; optionally pulse frame_start and/or clr in its WRITE cycle.
  task automatic do_write(input bit port, input logic [3:0] slot, input logic [3:0] data,
                          input bit with_frame, input bit with_clr);
    bit got;
    got = 1'b0;
    if (port) begin
      bus.b_slot = slot; bus.b_data = data; bus.b_req = 1'b1;
    end else begin
      bus.a_slot = slot; bus.a_data = data; bus.a_req = 1'b1;
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (port ? bus.b_gnt : bus.a_gnt) begin
        got = 1'b1;
        break;
      end
    end
    check(port ? "b_gnt" : "a_gnt", {47'd0, got}, 48'd1);
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
    frame_start = with_frame;
    clr = with_clr;
    tick();
    frame_start = 1'b0;
    clr = 1'b0;
  endtask

  initial begin
    bit got;
    int ngr;
    int gap_err;
    bit prev;
    bit g;
    bit order [4];

    rst = 1'b1; frame_start = 1'b0; clr = 1'b0;
    cursor_en = 1'b0; cursor_slot = 4'd0;
    bus.a_req = 1'b0; bus.a_slot = 4'd0; bus.a_data = 4'd0;
    bus.b_req = 1'b0; bus.b_slot = 4'd0; bus.b_data = 4'd0;

    vecs[0] = '{1'b0, 4'd0,  4'd2,  1'b1, 48'h2FFF_FFFF_FFFF};
    vecs[1] = '{1'b0, 4'd5,  4'd4,  1'b1, 48'h2FFF_F4FF_FFFF};
    vecs[2] = '{1'b1, 4'd11, 4'd9,  1'b1, 48'h2FFF_F4FF_FFF9};
    vecs[3] = '{1'b1, 4'd6,  4'd0,  1'b1, 48'h2FFF_F40F_FFF9};
    vecs[4] = '{1'b0, 4'd0,  4'hF,  1'b1, 48'hFFFF_F40F_FFF9};
    vecs[5] = '{1'b1, 4'd13, 4'd3,  1'b0, 48'hFFFF_F40F_FFF9};

    tick(); tick(); tick();
    check("rst_concat", numbers_concat, 48'hFFFF_FFFF_FFFF);
    check("rst_a_gnt", {47'd0, bus.a_gnt}, 48'd0);
    check("rst_b_gnt", {47'd0, bus.b_gnt}, 48'd0);
    check("rst_pending", {47'd0, pending}, 48'd0);
    rst = 1'b0;
    tick();

    // Reset held across a WRITE cycle drops the write
    bus.a_slot = 4'd2; bus.a_data = 4'd5; bus.a_req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.a_gnt) begin
        got = 1'b1;
        break;
      end
    end
    check("midrst_gnt", {47'd0, got}, 48'd1);
    rst = 1'b1;
    bus.a_req = 1'b0;
    tick(); tick(); tick();
    check("midrst_gnt_low", {46'd0, bus.a_gnt, bus.b_gnt}, 48'd0);
    rst = 1'b0;
    frame();
    check("midrst_concat", numbers_concat, 48'hFFFF_FFFF_FFFF);
    check("midrst_pending", {47'd0, pending}, 48'd0);

    for (int v = 0; v < 6; v++) begin
      do_write(vecs[v].port, vecs[v].slot, vecs[v].data, 1'b0, 1'b0);
      check($sformatf("vec%0d_pend", v), {47'd0, pending}, {47'd0, vecs[v].exp_pend});
      frame();
      check($sformatf("vec%0d_concat", v), numbers_concat, vecs[v].exp_concat);
      check($sformatf("vec%0d_pend_clr", v), {47'd0, pending}, 48'd0);
    end

    // Contention: last grant went to B, so A leads and they alternate
    bus.a_slot = 4'd1; bus.a_data = 4'd1; bus.b_slot = 4'd2; bus.b_data = 4'd2;
    bus.a_req = 1'b1; bus.b_req = 1'b1;
    ngr = 0; gap_err = 0; prev = 1'b0;
    for (int c = 0; c < 40 && ngr < 4; c++) begin
      tick();
      g = bus.a_gnt | bus.b_gnt;
      if (bus.a_gnt && bus.b_gnt) gap_err++;
      if (g && prev) gap_err++;
      if (g) begin
        order[ngr] = bus.b_gnt;
        ngr++;
        if (ngr == 4) begin
          bus.a_req = 1'b0;
          bus.b_req = 1'b0;
        end
      end
      prev = g;
    end
    tick();
    check("cont_ngrants", 48'(ngr), 48'd4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("cont_order%0d", k), {47'd0, order[k]}, {47'd0, k[0]});
    end
    check("cont_gap", 48'(gap_err), 48'd0);
    frame();
    check("cont_concat", numbers_concat, 48'hF12F_F40F_FFF9);

    // Write landing in the same cycle as frame_start misses that frame
    do_write(1'b0, 4'd3, 4'd7, 1'b1, 1'b0);
    check("samefr_concat", numbers_concat, 48'hF12F_F40F_FFF9);
    check("samefr_pending", {47'd0, pending}, 48'd1);
    frame();
    check("samefr_next", numbers_concat, 48'hF127_F40F_FFF9);
    check("samefr_pend_clr", {47'd0, pending}, 48'd0);

    // clr and a write in the same cycle: clear first, write survives
    do_write(1'b1, 4'd11, 4'd9, 1'b0, 1'b1);
    check("clrwr_pending", {47'd0, pending}, 48'd1);
    frame();
    check("clrwr_concat", numbers_concat, 48'hFFFF_FFFF_FFF9);
    check("clrwr_pend_clr", {47'd0, pending}, 48'd0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_pending", {47'd0, pending}, 48'd1);
    frame();
    check("clr_concat", numbers_concat, 48'hFFFF_FFFF_FFFF);

    // Blink with BLINK_FRAMES = 2 from a fresh reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    do_write(1'b0, 4'd1, 4'd6, 1'b0, 1'b0);
    cursor_en = 1'b1;
    cursor_slot = 4'd1;
    for (int f = 0; f < 5; f++) begin
      frame();
      check($sformatf("blink%0d", f), {44'd0, numbers_concat[43:40]},
            (f == 2 || f == 3) ? 48'hF : 48'h6);
    end
    cursor_slot = 4'd12;
    for (int f = 0; f < 3; f++) begin
      frame();
      check($sformatf("noblink%0d", f), {44'd0, numbers_concat[43:40]}, 48'h6);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/digit_board_ctrl.md
# digit_board_ctrl

Owns the twelve 4-bit digit slots shown on the VGA screen (two rows of six) and produces the 48-bit `numbers_concat` bus consumed by the screen renderer. Two requesters, game logic (port A) and keypad entry (port B), share one write port into a working copy under round-robin arbitration. The working copy is published to the renderer only at frame boundaries, so a frame never shows a half-updated board. Optionally, one slot blinks as an entry cursor.

## Interface
- `BLINK_FRAMES`, default 30: frames per blink half-period; legal range 1..255.
- `clk`  in  1  system/pixel clock.
- `rst`  in  1  synchronous, active-high reset.
- `frame_start`  in  1  one-cycle pulse from the VGA timing generator at the start of vertical blanking.
- `clr`  in  1  one-cycle pulse; sets every working slot to 4'hF (blank).
- `a_req`  in  1  port A write request; held with `a_slot`/`a_data` until `a_gnt`.
- `a_slot`  in  4  target slot, 0..11.
- `a_data`  in  4  digit 0..9; 4'hF blanks the slot (10..14 also render blank).
- `a_gnt`  out  1  one-cycle grant; the write commits on this cycle.
- `b_req`, `b_slot`, `b_data`, `b_gnt`: same as the A port, for port B.
- `cursor_en`  in  1  enables blinking of `cursor_slot`.
- `cursor_slot`  in  4  slot to blink; values ≥12 mean no blink.
- `numbers_concat`  out  48  published board. Slot 0 is bits [47:44] (top-left); slot 11 is bits [3:0] (bottom-right).
- `pending`  out  1  high when the working copy holds writes not yet published.

## Operation
- Storage: 12×4 working registers, a 48-bit published register, a blink counter (8 bits) and a blink phase bit.
- Arbiter FSM, two states:
  - ARB: if any request is high, grant one requester and go to WRITE. With both requests high, the winner is the requester that did not win last; the `last` pointer updates on every grant.
  - WRITE: the granted requester's `gnt` is high for this cycle only. `working[slot] <= data`, using the port values present in this cycle. Return to ARB.
- Throughput is at most one write per 2 cycles. A requester sees no grant in the cycle after its own grant, so it can drop `req` without a spurious regrant.
- Slot ≥12: the grant is still issued and no storage changes.
- `clr` may arrive in any state. It blanks all working slots. If a WRITE commits in the same cycle, `clr` applies first and the write then lands, so the written slot holds the new data.
- On `frame_start`:
  - `numbers_concat <= working` (the register values from before any same-cycle write or clear).
  - When `cursor_en` is high, `cursor_slot` < 12 and phase = OFF, that slot is published as 4'hF instead.
- Blink: the counter increments on each `frame_start`. When it reaches `BLINK_FRAMES-1` it wraps to 0 and the phase toggles. The phase starts ON (cursor visible).
- `pending`:
  - Set by any committed write to a valid slot, or by `clr`.
  - Cleared by `frame_start` unless a write or `clr` happens in that same cycle, in which case it stays set.

## Timing
- Reset (synchronous, on the `clk` edge while `rst` is high; overrides all other inputs):
  - FSM to ARB; `a_gnt` = `b_gnt` = 0.
  - All working slots 4'hF; `numbers_concat` = 48'hFFFF_FFFF_FFFF.
  - `pending` = 0; blink counter 0, phase ON.
  - `last` = B, so A wins the first contention.
- Reset asserted during WRITE drops that write. A requester still holding `req` is re-arbitrated after reset.
- Request latency: `req` sampled high in cycle N (FSM in ARB) gives `gnt` high in cycle N+1. The data is visible in `numbers_concat` on the cycle after the next `frame_start`.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Reset → `numbers_concat` = 48'hFFFFFFFFFFFF, both grants 0, `pending` 0. Hold `rst` 3 cycles mid-WRITE → no write lands.
- A writes slot 0 = 2, slot 5 = 4, then `frame_start` → `numbers_concat[47:44]` = 2, `[27:24]` = 4, other slots F. `pending` goes 1, then 0 after `frame_start`.
- A and B both hold `req` for 4 grants → grant order A, B, A, B. Each `gnt` is a single cycle, with at least one cycle between grants.
- Write slot 3 = 7 in the same cycle as `frame_start` → published slot 3 is still F and `pending` = 1. The next `frame_start` publishes 7.
- `clr` in the same cycle as a B write of slot 11 = 9 → after publish, slot 11 = 9 and all other slots F. A write to slot 13 → grant issued, board unchanged, `pending` unchanged.
- `BLINK_FRAMES` = 2, `cursor_en` = 1, `cursor_slot` = 1 holding 6 → published slot 1 over successive frames: 6, 6, F, F, 6. With `cursor_slot` = 12 → always 6.
